sm_warp_sched: RTL and testbench
================================

SM_WARP_SCHED -- requirements
Module: sm_warp_sched

Interface
REQ-001 SHALL have parameter NUM_WARP, default `NUM_WARP, number of warp slots.
REQ-002 SHALL have parameter DEPTH_WARP, default `DEPTH_WARP, width of a warp id, equal to log2(NUM_WARP).
REQ-003 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port launch_valid_i  in  1  warp assigned, one cycle pulse.
REQ-006 SHALL have port launch_wid_i  in  DEPTH_WARP  id of the launched warp.
REQ-007 SHALL have port issue_valid_o  out  1  registered: a warp is offered for instruction issue.
REQ-008 SHALL have port issue_wid_o  out  DEPTH_WARP  registered id of the offered warp.
REQ-009 SHALL have port issue_ready_i  in  1  pipeline accepts the offered warp.
REQ-010 SHALL have port wb_valid_i  in  1  writeback of a previously issued warp completes.
REQ-011 SHALL have port wb_wid_i  in  DEPTH_WARP  id of the completing warp.
REQ-012 SHALL have port wb_exit_i  in  1  completed instruction was EXIT.
REQ-013 SHALL have port wb_bar_i  in  1  completed instruction was BAR; used only with the barrier feature.
REQ-014 SHALL have port done_valid_o  out  1  registered: a warp has finished.
REQ-015 SHALL have port done_wid_o  out  DEPTH_WARP  registered id of the finished warp.
REQ-016 SHALL have port done_ready_i  in  1  consumer, typically sm_warp_assign, accepts the done report.

Function
REQ-017 SHALL keep a per-warp state: FREE, READY, PEND, BAR, DONE.
REQ-018 SHALL, on launch_valid_i to a FREE warp, move that warp to READY. A launch to a non-FREE warp SHALL be ignored.
REQ-019 SHALL load the issue register whenever issue_valid_o=0 or (issue_valid_o & issue_ready_i). The load uses the round-robin pick over warps registered READY.
REQ-020 SHALL move the picked warp from READY to PEND in the same edge that it is loaded into the issue register, so a warp is never offered twice.
REQ-021 SHALL start the round-robin search at (last picked id + 1) mod NUM_WARP, wrapping at NUM_WARP-1 to 0. The pointer SHALL reset to 0.
REQ-022 SHALL hold issue_valid_o/issue_wid_o stable while issue_valid_o=1 and issue_ready_i=0.
REQ-023 SHALL deassert issue_valid_o on the load edge when no warp is READY.
REQ-024 SHALL give a minimum latency of 2 cycles from launch to offer: launch at edge N -> READY after N -> issue_valid_o=1 after N+1.
REQ-025 SHALL handle writeback to a PEND warp as follows:
  - wb_exit_i=1 -> DONE
  - else wb_bar_i=1 -> BAR, with the barrier feature only
  - else -> READY
REQ-026 SHALL give wb_exit_i priority over wb_bar_i. Writeback to a non-PEND warp SHALL be ignored.
REQ-027 SHALL arbitrate on registered state only. A warp turning READY on edge N is eligible from the pick at edge N+1.
REQ-028 SHALL allow launch, writeback and issue load in the same cycle on different warps without loss.
REQ-029 SHALL load the done register whenever done_valid_o=0 or (done_valid_o & done_ready_i). The load selects the lowest-index DONE warp.
REQ-030 SHALL move the warp loaded into the done register to FREE on that edge, and hold done outputs stable until done_ready_i.
REQ-031 SHALL reach FREE by DONE -> done accept only. No other path to FREE exists.

Reset
REQ-032 SHALL, while rst=1 at a clock edge, set every warp to FREE, issue_valid_o=0, issue_wid_o=0, done_valid_o=0, done_wid_o=0 and the RR pointer to 0.
REQ-033 SHALL abort any in-flight offer or done report on reset mid-operation, with no output glitch before the edge.

Configuration
REQ-034 SHALL, with macro SM_WARP_SCHED_BARRIER_EN defined, honour wb_bar_i and the BAR state.
REQ-035 SHALL, with SM_WARP_SCHED_BARRIER_EN defined, release all BAR warps to READY on the edge after no warp is READY or PEND and at least one warp is BAR. DONE and FREE warps SHALL not block the release.
REQ-036 SHALL, without SM_WARP_SCHED_BARRIER_EN, ignore wb_bar_i, treat a BAR writeback as a plain writeback to READY, and never enter the BAR state.

Verification
REQ-037 SHALL cover: launch wid 3, issue_ready_i=1 -> issue_valid_o=1, wid 3 two cycles after launch, then 0.
REQ-038 SHALL cover: launch 0,1,2, issue_ready_i=1, immediate wb each -> issue order 0,1,2,0,1,2; wrap after NUM_WARP-1 verified with wid NUM_WARP-1.
REQ-039 SHALL cover: warp 5 offered, issue_ready_i=0 for 4 cycles -> wid 5 held stable; warp 6 launched meanwhile is offered only after accept.
REQ-040 SHALL cover: wb wid 2 with exit, done_ready_i=0 for 3 cycles -> done_valid_o held, wid 2; on accept warp 2 is FREE and re-launchable.
REQ-041 SHALL cover, with BARRIER_EN: warps 0,1 reach BAR; warp 1 wb delayed -> no issue until both BAR, then both offered. Without the macro, bar wb returns the warp to READY at once.
REQ-042 SHALL cover: rst=1 while issue_valid_o=1 and done_valid_o=1 -> both 0 after the edge; relaunch of the same wid is accepted.

Source files
------------

// File: rtl/sm_warp_sched.sv
// Per-warp lifecycle tracker with a round-robin issue offer and a lowest-index done report.
// Define SM_WARP_SCHED_BARRIER_EN to honour wb_bar_i and the BAR barrier state.
`ifndef NUM_WARP
`define NUM_WARP 8
`endif
`ifndef DEPTH_WARP
`define DEPTH_WARP 3
`endif

module sm_warp_sched #(
  parameter int NUM_WARP   = `NUM_WARP,
  parameter int DEPTH_WARP = `DEPTH_WARP
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  launch_valid_i,
  input  logic [DEPTH_WARP-1:0] launch_wid_i,
  output logic                  issue_valid_o,
  output logic [DEPTH_WARP-1:0] issue_wid_o,
  input  logic                  issue_ready_i,
  input  logic                  wb_valid_i,
  input  logic [DEPTH_WARP-1:0] wb_wid_i,
  input  logic                  wb_exit_i,
  input  logic                  wb_bar_i,
  output logic                  done_valid_o,
  output logic [DEPTH_WARP-1:0] done_wid_o,
  input  logic                  done_ready_i
);

  typedef enum logic [2:0] {
    W_FREE  = 3'd0,
    W_READY = 3'd1,
    W_PEND  = 3'd2,
    W_BAR   = 3'd3,
    W_DONE  = 3'd4
  } warp_state_e;

  warp_state_e           state_r     [NUM_WARP];
  warp_state_e           state_nxt_s [NUM_WARP];
  logic [DEPTH_WARP-1:0] rr_ptr_r;
  logic                  issue_valid_r;
  logic [DEPTH_WARP-1:0] issue_wid_r;
  logic                  done_valid_r;
  logic [DEPTH_WARP-1:0] done_wid_r;

  logic [NUM_WARP-1:0]   ready_vec_s;
  logic [NUM_WARP-1:0]   done_vec_s;
  logic                  issue_load_s;
  logic                  done_load_s;
  logic                  pick_found_s;
  logic [DEPTH_WARP-1:0] pick_wid_s;
  logic [DEPTH_WARP-1:0] rr_ptr_nxt_s;
  logic                  done_found_s;
  logic [DEPTH_WARP-1:0] done_pick_s;
  logic                  release_s;

  // Modular increment of a warp id; the sum never exceeds 2*NUM_WARP-2.
  function automatic logic [DEPTH_WARP-1:0] wrap_add(input logic [DEPTH_WARP-1:0] base,
                                                     input int offs);
    int sum;
    sum = int'(base) + offs;
    if (sum >= NUM_WARP) begin
      sum = sum - NUM_WARP;
    end else begin
      sum = sum;
    end
    return sum[DEPTH_WARP-1:0];
  endfunction

  assign issue_load_s  = !issue_valid_r || issue_ready_i;
  assign done_load_s   = !done_valid_r || done_ready_i;
  assign issue_valid_o = issue_valid_r;
  assign issue_wid_o   = issue_wid_r;
  assign done_valid_o  = done_valid_r;
  assign done_wid_o    = done_wid_r;

  // Decode registered warp states into READY and DONE masks
  always_comb begin
    ready_vec_s = {NUM_WARP{1'b0}};
    done_vec_s  = {NUM_WARP{1'b0}};
    for (int w = 0; w < NUM_WARP; w++) begin
      ready_vec_s[w] = (state_r[w] == W_READY);
      done_vec_s[w]  = (state_r[w] == W_DONE);
    end
  end

  // Round-robin search over READY warps starting at the pointer
  always_comb begin
    pick_found_s = 1'b0;
    pick_wid_s   = {DEPTH_WARP{1'b0}};
    for (int i = 0; i < NUM_WARP; i++) begin
      if (!pick_found_s && ready_vec_s[wrap_add(rr_ptr_r, i)]) begin
        pick_found_s = 1'b1;
        pick_wid_s   = wrap_add(rr_ptr_r, i);
      end else begin
        pick_found_s = pick_found_s;
      end
    end
    rr_ptr_nxt_s = wrap_add(pick_wid_s, 1);
  end

  // Lowest-index DONE warp (descending scan, last hit wins)
  always_comb begin
    done_found_s = 1'b0;
    done_pick_s  = {DEPTH_WARP{1'b0}};
    for (int w = NUM_WARP - 1; w >= 0; w--) begin
      if (done_vec_s[w]) begin
        done_found_s = 1'b1;
        done_pick_s  = DEPTH_WARP'(w);
      end else begin
        done_found_s = done_found_s;
      end
    end
  end

`ifdef SM_WARP_SCHED_BARRIER_EN
  logic [NUM_WARP-1:0] pend_vec_s;
  logic [NUM_WARP-1:0] bar_vec_s;

  // Barrier release once nothing is READY or PEND and someone waits at BAR
  always_comb begin
    pend_vec_s = {NUM_WARP{1'b0}};
    bar_vec_s  = {NUM_WARP{1'b0}};
    for (int w = 0; w < NUM_WARP; w++) begin
      pend_vec_s[w] = (state_r[w] == W_PEND);
      bar_vec_s[w]  = (state_r[w] == W_BAR);
    end
    release_s = (ready_vec_s == {NUM_WARP{1'b0}}) && (pend_vec_s == {NUM_WARP{1'b0}}) &&
                (bar_vec_s != {NUM_WARP{1'b0}});
  end
`else
  logic unused_bar_s;
  assign unused_bar_s = wb_bar_i;
  assign release_s    = 1'b0;
`endif

  // Per-warp next state; each event only touches warps in its own source state
  always_comb begin
    for (int w = 0; w < NUM_WARP; w++) begin
      state_nxt_s[w] = state_r[w];
      case (state_r[w])
        W_FREE: begin
          if (launch_valid_i && (launch_wid_i == DEPTH_WARP'(w))) begin
            state_nxt_s[w] = W_READY;
          end else begin
            state_nxt_s[w] = W_FREE;
          end
        end
        W_READY: begin
          if (issue_load_s && pick_found_s && (pick_wid_s == DEPTH_WARP'(w))) begin
            state_nxt_s[w] = W_PEND;
          end else begin
            state_nxt_s[w] = W_READY;
          end
        end
        W_PEND: begin
          if (wb_valid_i && (wb_wid_i == DEPTH_WARP'(w))) begin
            if (wb_exit_i) begin
              state_nxt_s[w] = W_DONE;
`ifdef SM_WARP_SCHED_BARRIER_EN
            end else if (wb_bar_i) begin
              state_nxt_s[w] = W_BAR;
`endif
            end else begin
              state_nxt_s[w] = W_READY;
            end
          end else begin
            state_nxt_s[w] = W_PEND;
          end
        end
        W_BAR: begin
          if (release_s) begin
            state_nxt_s[w] = W_READY;
          end else begin
            state_nxt_s[w] = W_BAR;
          end
        end
        W_DONE: begin
          if (done_load_s && done_found_s && (done_pick_s == DEPTH_WARP'(w))) begin
            state_nxt_s[w] = W_FREE;
          end else begin
            state_nxt_s[w] = W_DONE;
          end
        end
        default: begin
          state_nxt_s[w] = W_FREE;
        end
      endcase
    end
  end

  // Warp state, round-robin pointer and the two output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < NUM_WARP; w++) begin
        state_r[w] <= W_FREE;
      end
      rr_ptr_r      <= {DEPTH_WARP{1'b0}};
      issue_valid_r <= 1'b0;
      issue_wid_r   <= {DEPTH_WARP{1'b0}};
      done_valid_r  <= 1'b0;
      done_wid_r    <= {DEPTH_WARP{1'b0}};
    end else begin
      for (int w = 0; w < NUM_WARP; w++) begin
        state_r[w] <= state_nxt_s[w];
      end
      if (issue_load_s) begin
        if (pick_found_s) begin
          issue_valid_r <= 1'b1;
          issue_wid_r   <= pick_wid_s;
          rr_ptr_r      <= rr_ptr_nxt_s;
        end else begin
          issue_valid_r <= 1'b0;
        end
      end
      if (done_load_s) begin
        if (done_found_s) begin
          done_valid_r <= 1'b1;
          done_wid_r   <= done_pick_s;
        end else begin
          done_valid_r <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sm_warp_sched.sv
// Bench for sm_warp_sched: directed scenarios plus random traffic, all checked against a
// behavioural warp-lifecycle model; barrier expectations follow SM_WARP_SCHED_BARRIER_EN.
`timescale 1ns/1ps
module tb_sm_warp_sched;
  localparam int NW = 8;
  localparam int DW = 3;
  localparam int S_FREE = 0, S_READY = 1, S_PEND = 2, S_BAR = 3, S_DONE = 4;
`ifdef SM_WARP_SCHED_BARRIER_EN
  localparam bit BAR_EN = 1'b1;
`else
  localparam bit BAR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          launch_valid_i, issue_valid_o, issue_ready_i, wb_valid_i, wb_exit_i, wb_bar_i;
  logic          done_valid_o, done_ready_i;
  logic [DW-1:0] launch_wid_i, issue_wid_o, wb_wid_i, done_wid_o;

  sm_warp_sched #(.NUM_WARP(NW), .DEPTH_WARP(DW)) dut (
    .clk(clk), .rst(rst),
    .launch_valid_i(launch_valid_i), .launch_wid_i(launch_wid_i),
    .issue_valid_o(issue_valid_o), .issue_wid_o(issue_wid_o), .issue_ready_i(issue_ready_i),
    .wb_valid_i(wb_valid_i), .wb_wid_i(wb_wid_i), .wb_exit_i(wb_exit_i), .wb_bar_i(wb_bar_i),
    .done_valid_o(done_valid_o), .done_wid_o(done_wid_o), .done_ready_i(done_ready_i)
  );

  always #5 clk = ~clk;

  // Reference model: warp lifecycle as integer states plus the two offered slots
  int m_st [NW];
  int m_ptr, m_iw, m_dw;
  bit m_iv, m_dv;
  int n_cmp = 0, n_err = 0;
  bit cmp_en = 1'b0;

  task automatic model_step();
    int ost [NW];
    bit iss_load, dn_load, busy, any_bar;
    int idx;
    if (rst) begin
      for (int i = 0; i < NW; i++) m_st[i] = S_FREE;
      m_ptr = 0; m_iv = 1'b0; m_iw = 0; m_dv = 1'b0; m_dw = 0;
      return;
    end
    for (int i = 0; i < NW; i++) ost[i] = m_st[i];
    iss_load = !m_iv || issue_ready_i;
    dn_load  = !m_dv || done_ready_i;
    if (launch_valid_i && ost[launch_wid_i] == S_FREE) m_st[launch_wid_i] = S_READY;
    if (wb_valid_i && ost[wb_wid_i] == S_PEND)
      m_st[wb_wid_i] = wb_exit_i ? S_DONE : ((wb_bar_i && BAR_EN) ? S_BAR : S_READY);
    busy = 1'b0; any_bar = 1'b0;
    for (int i = 0; i < NW; i++) begin
      if (ost[i] == S_READY || ost[i] == S_PEND) busy = 1'b1;
      if (ost[i] == S_BAR) any_bar = 1'b1;
    end
    if (BAR_EN && !busy && any_bar)
      for (int i = 0; i < NW; i++) if (ost[i] == S_BAR) m_st[i] = S_READY;
    if (iss_load) begin
      m_iv = 1'b0;
      for (int k = 0; k < NW; k++) begin
        idx = (m_ptr + k) % NW;
        if (!m_iv && ost[idx] == S_READY) begin
          m_iv = 1'b1; m_iw = idx; m_st[idx] = S_PEND;
        end
      end
      if (m_iv) m_ptr = (m_iw + 1) % NW;
    end
    if (dn_load) begin
      m_dv = 1'b0;
      for (int k = NW - 1; k >= 0; k--) if (ost[k] == S_DONE) begin m_dv = 1'b1; m_dw = k; end
      if (m_dv) m_st[m_dw] = S_FREE;
    end
  endtask

  function automatic bit model_idle();
    bit idle;
    idle = !m_iv && !m_dv;
    for (int i = 0; i < NW; i++) if (m_st[i] != S_FREE) idle = 1'b0;
    return idle;
  endfunction

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle comparison of DUT outputs against the model
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      n_cmp++;
      if (issue_valid_o !== m_iv) begin
        n_err++; $display("FAIL issue_valid at %0t: got %0b want %0b", $time, issue_valid_o, m_iv);
      end
      if (m_iv) begin
        n_cmp++;
        if (int'(issue_wid_o) != m_iw) begin
          n_err++; $display("FAIL issue_wid at %0t: got %0d want %0d", $time, issue_wid_o, m_iw);
        end
      end
      n_cmp++;
      if (done_valid_o !== m_dv) begin
        n_err++; $display("FAIL done_valid at %0t: got %0b want %0b", $time, done_valid_o, m_dv);
      end
      if (m_dv) begin
        n_cmp++;
        if (int'(done_wid_o) != m_dw) begin
          n_err++; $display("FAIL done_wid at %0t: got %0d want %0d", $time, done_wid_o, m_dw);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++; $display("FAIL %s at %0t: got %0d want %0d", name, $time, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic clr();
    launch_valid_i = 1'b0; wb_valid_i = 1'b0; wb_exit_i = 1'b0; wb_bar_i = 1'b0;
  endtask

  task automatic launch(input int wid);
    launch_valid_i = 1'b1; launch_wid_i = DW'(wid);
  endtask

  // Retire every outstanding warp with EXIT writebacks and accept all done reports
  task automatic drain();
    int guard;
    for (guard = 0; guard < 200; guard++) begin
      if (model_idle()) break;
      clr(); issue_ready_i = 1'b1; done_ready_i = 1'b1;
      for (int i = 0; i < NW; i++)
        if (!wb_valid_i && m_st[i] == S_PEND) begin
          wb_valid_i = 1'b1; wb_wid_i = DW'(i); wb_exit_i = 1'b1;
        end
      cyc();
    end
    clr();
    chk("drain_complete", int'(model_idle()), 1);
    chk("drain_issue_idle", int'(issue_valid_o), 0);
    chk("drain_done_idle", int'(done_valid_o), 0);
  endtask

  int got[$];
  int n_seen [NW];
  int exp_ord [6] = '{0, 1, 2, 0, 1, 2};
  int prev_acc, start, w;

  initial begin
    clr(); issue_ready_i = 1'b0; done_ready_i = 1'b0; launch_wid_i = '0; wb_wid_i = '0;
    rst = 1'b1;
    cyc(); cyc();
    cmp_en = 1'b1;
    chk("rst_issue_valid", int'(issue_valid_o), 0);
    chk("rst_issue_wid", int'(issue_wid_o), 0);
    chk("rst_done_valid", int'(done_valid_o), 0);
    chk("rst_done_wid", int'(done_wid_o), 0);
    rst = 1'b0;

    // Launch-to-offer latency
    issue_ready_i = 1'b1; launch(3); cyc(); clr();
    chk("lat_cycle1_valid", int'(issue_valid_o), 0);
    cyc();
    chk("lat_cycle2_valid", int'(issue_valid_o), 1);
    chk("lat_cycle2_wid", int'(issue_wid_o), 3);
    cyc();
    chk("lat_cycle3_valid", int'(issue_valid_o), 0);
    drain();

    // Round-robin order with immediate writebacks
    got.delete(); prev_acc = -1;
    for (int i = 0; i < NW; i++) n_seen[i] = 0;
    issue_ready_i = 1'b1; done_ready_i = 1'b1;
    for (int c = 0; c < 12; c++) begin
      clr();
      if (c < 3) launch(c);
      if (prev_acc >= 0) begin
        wb_valid_i = 1'b1; wb_wid_i = DW'(prev_acc); wb_exit_i = (n_seen[prev_acc] >= 2);
      end
      prev_acc = issue_valid_o ? int'(issue_wid_o) : -1;
      if (issue_valid_o) begin got.push_back(int'(issue_wid_o)); n_seen[issue_wid_o]++; end
      cyc();
    end
    clr();
    chk("rr_offer_count", got.size(), 6);
    for (int k = 0; k < 6; k++) chk("rr_order", (k < got.size()) ? got[k] : -1, exp_ord[k]);
    drain();

    // Pointer wrap: with 0 and NUM_WARP-1 both READY after picking 6, 7 must win
    issue_ready_i = 1'b1; launch(6); cyc(); clr();
    launch(0); cyc(); clr();
    chk("wrap_first_wid", int'(issue_wid_o), 6);
    issue_ready_i = 1'b0; launch(7); cyc(); clr();
    issue_ready_i = 1'b1; cyc();
    chk("wrap_hi_wid", int'(issue_wid_o), NW - 1);
    cyc();
    chk("wrap_lo_wid", int'(issue_wid_o), 0);
    drain();

    // Back-pressure hold; a later launch waits for the accept
    issue_ready_i = 1'b0; launch(5); cyc(); clr(); cyc();
    for (int k = 0; k < 4; k++) begin
      chk("hold_valid", int'(issue_valid_o), 1);
      chk("hold_wid", int'(issue_wid_o), 5);
      if (k == 0) launch(6);
      cyc(); clr();
    end
    issue_ready_i = 1'b1; cyc();
    chk("after_accept_wid", int'(issue_wid_o), 6);
    cyc();
    chk("after_accept_idle", int'(issue_valid_o), 0);
    drain();

    // Exit, held done report, accept and relaunch
    issue_ready_i = 1'b1; done_ready_i = 1'b0; launch(2); cyc(); clr(); cyc();
    chk("exit_offer_wid", int'(issue_wid_o), 2);
    cyc();
    wb_valid_i = 1'b1; wb_wid_i = DW'(2); wb_exit_i = 1'b1; cyc(); clr();
    cyc();
    for (int k = 0; k < 3; k++) begin
      chk("done_hold_valid", int'(done_valid_o), 1);
      chk("done_hold_wid", int'(done_wid_o), 2);
      cyc();
    end
    done_ready_i = 1'b1; cyc();
    chk("done_accept_idle", int'(done_valid_o), 0);
    launch(2); cyc(); clr(); cyc();
    chk("relaunch_valid", int'(issue_valid_o), 1);
    chk("relaunch_wid", int'(issue_wid_o), 2);
    drain();

    // Barrier writebacks
    issue_ready_i = 1'b1; done_ready_i = 1'b1; launch(0); cyc(); clr();
    launch(1); cyc(); clr();
    cyc();
    wb_valid_i = 1'b1; wb_wid_i = DW'(0); wb_bar_i = 1'b1; cyc(); clr();
`ifdef SM_WARP_SCHED_BARRIER_EN
    for (int k = 0; k < 3; k++) begin
      chk("bar_wait_idle", int'(issue_valid_o), 0);
      cyc();
    end
    wb_valid_i = 1'b1; wb_wid_i = DW'(1); wb_bar_i = 1'b1; cyc(); clr();
    chk("bar_both_idle", int'(issue_valid_o), 0);
    cyc();
    chk("bar_release_idle", int'(issue_valid_o), 0);
    cyc();
    chk("bar_offer_a_valid", int'(issue_valid_o), 1);
    chk("bar_offer_a_wid", int'(issue_wid_o), 0);
    cyc();
    chk("bar_offer_b_valid", int'(issue_valid_o), 1);
    chk("bar_offer_b_wid", int'(issue_wid_o), 1);
`else
    chk("nobar_wb_edge_idle", int'(issue_valid_o), 0);
    cyc();
    chk("nobar_reoffer_valid", int'(issue_valid_o), 1);
    chk("nobar_reoffer_wid", int'(issue_wid_o), 0);
`endif
    drain();

    // Reset while both offers are live
    issue_ready_i = 1'b1; done_ready_i = 1'b0; launch(4); cyc(); clr(); cyc();
    cyc();
    issue_ready_i = 1'b0; launch(5); wb_valid_i = 1'b1; wb_wid_i = DW'(4); wb_exit_i = 1'b1;
    cyc(); clr();
    cyc();
    chk("prerst_issue_valid", int'(issue_valid_o), 1);
    chk("prerst_done_valid", int'(done_valid_o), 1);
    rst = 1'b1; cyc();
    chk("midrst_issue_valid", int'(issue_valid_o), 0);
    chk("midrst_done_valid", int'(done_valid_o), 0);
    chk("midrst_issue_wid", int'(issue_wid_o), 0);
    chk("midrst_done_wid", int'(done_wid_o), 0);
    rst = 1'b0; issue_ready_i = 1'b1; launch(5); cyc(); clr(); cyc();
    chk("postrst_offer_wid", int'(issue_wid_o), 5);
    drain();

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      clr();
      rst = ($urandom_range(0, 499) == 0);
      issue_ready_i = ($urandom_range(0, 3) != 0);
      done_ready_i  = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 2) == 0) launch(int'($urandom_range(0, NW - 1)));
      if ($urandom_range(0, 1) == 0) begin
        start = int'($urandom_range(0, NW - 1));
        for (int k = 0; k < NW; k++) begin
          w = (start + k) % NW;
          if (!wb_valid_i && m_st[w] == S_PEND && !(m_iv && m_iw == w)) begin
            wb_valid_i = 1'b1; wb_wid_i = DW'(w);
            wb_exit_i = ($urandom_range(0, 3) == 0);
            wb_bar_i  = ($urandom_range(0, 2) == 0);
          end
        end
      end else if ($urandom_range(0, 7) == 0) begin
        wb_valid_i = 1'b1; wb_wid_i = DW'($urandom_range(0, NW - 1));
        wb_exit_i = $urandom_range(0, 1) == 0; wb_bar_i = $urandom_range(0, 1) == 0;
      end
      cyc();
    end
    rst = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
